// File: rtl/lut_reg_pipe.sv
// lut_reg_pipe: DEPTH-stage register pipeline, valid tracking, stall, flush.
// Define LUT_REG_PIPE_OCC_EN to add the occ occupancy counter port.
module lut_reg_pipe #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
`ifdef LUT_REG_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;

  // Data stages shift regardless of valid; bubbles keep their slot.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= INIT;
      end
      v <= '0;
    end else if (en) begin
      d[0] <= a;
      v[0] <= a_valid;
      for (int i = 1; i < DEPTH; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
      end
    end
  end

  assign y       = d[DEPTH-1];
  assign y_valid = v[DEPTH-1];

`ifdef LUT_REG_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);

  // Tracks popcount(v) incrementally: one in, one out per advance.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + OW'(a_valid) - OW'(v[DEPTH-1]);
    end
  end
`endif

endmodule

// File: doc/lut_reg_pipe.md
# lut_reg_pipe

Parametrised, LUT/FF-mapped register pipeline with per-stage valid tracking, global stall enable and synchronous flush. It generalises the single-stage 8-bit enabled register to any data width and pipeline depth, and adds valid propagation and flush. It sits between datapath stages in generated designs and is exercised by the cycle-counting regression benches; its output must be stable before GSR settles at cycle 5000.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- INIT, 0, reset/flush value of every data stage (WIDTH bits)

- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; highest priority
- a  in  WIDTH  input data
- a_valid  in  1  input data qualifier
- en  in  1  advance enable; 0 stalls the whole pipeline
- flush  in  1  synchronous clear of pipeline contents
- y  out  WIDTH  data of last stage (registered)
- y_valid  out  1  valid of last stage (registered)
- occ  out  $clog2(DEPTH+1)  number of valid stages; present only with LUT_REG_PIPE_OCC_EN

## Operation
- State: d[0..DEPTH-1] (WIDTH bits each), v[0..DEPTH-1] (1 bit each); y=d[DEPTH-1], y_valid=v[DEPTH-1].
- Per rising edge, priority order:
  - reset=1: all d←INIT, all v←0, occ←0.
  - else flush=1: all d←INIT, all v←0, occ←0; a/a_valid on that cycle discarded, en ignored.
  - else en=1: d[0]←a, v[0]←a_valid; d[i]←d[i-1], v[i]←v[i-1] for i≥1. Data stages load regardless of valid (no data gating).
  - else (en=0): all state held.
- Invalid entries travel as bubbles; no collapsing, so order and spacing are preserved exactly.
- y is valid to consumers only when y_valid=1; when y_valid=0, y still equals the last-stage register (deterministic, INIT after reset/flush).
- No combinational path from any input to any output.

## Timing
- Latency: DEPTH enabled edges from capture at stage 0 to appearance at y, i.e. a sample applied before edge k with en=1 on edges k..k+DEPTH-1 is on y after edge k+DEPTH-1.
- Stall cycles (en=0) add one cycle of latency each; no data loss.
- Throughput: one sample per cycle with en held high.
- Reset values: y=INIT, y_valid=0, occ=0, valid from the first edge with reset=1.
- Reset or flush mid-stream: takes effect on that edge; all in-flight data lost; next edge with en=1 captures normally.
- DEPTH=1: single register, y follows a one enabled edge later.
- en and flush both 1: flush wins.

## Configuration
- LUT_REG_PIPE_OCC_EN defined: port occ present; registered counter updated on each edge: reset/flush→0; en=1→occ + a_valid − v[DEPTH-1]; en=0→hold. Always equals popcount(v); range 0..DEPTH, never wraps.
- Undefined: occ port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold reset=1 for 3 cycles with a=0xFF, a_valid=1, en=1 -> y=0x00, y_valid=0, occ=0 throughout and on the first cycle after release.
- Steady stream (WIDTH=8, DEPTH=4): a=0x0C, a_valid=1, en=1 constant after reset -> y_valid rises after the 4th enabled edge, then y=0x0C (signed 12) every cycle through cycle 5010; occ=4 steady.
- Stall: send 0x01..0x05 on consecutive cycles, en=0 for 2 cycles after 0x03 is accepted -> y outputs 0x01..0x05 in order, with sample 0x01 delayed 2 extra cycles and no duplicates or drops.
- Bubbles: a_valid pattern 1,0,1,1 with data 0x10,0x20,0x30,0x40 -> y_valid pattern 1,0,1,1 with y=0x10,0x20,0x30,0x40, 4 cycles later; occ peaks at 3.
- Flush: with 3 valid stages in flight, assert flush=1 and en=1 with a=0x55, a_valid=1 for one cycle -> next cycle y=INIT, y_valid=0, occ=0; 0x55 never appears at y.
- DEPTH=1, INIT=0xA5: after reset y=0xA5; a=0x3C, a_valid=1, en=1 -> y=0x3C, y_valid=1 one cycle later; en=0 holds it.
